// File: rtl/rs_alu_pkg.sv
// Shared types, ROB-id width, ALU opcode encodings and the common RS helper functions
// (CDB operand update, first-vacant / first-ready pickers, vacancy count).
package rs_alu_pkg;

  localparam int unsigned RobIdW  = 5;
  localparam int unsigned RsDepth = 16;
  localparam int unsigned RsIdxW  = 4;

  typedef logic [RobIdW-1:0] rob_id_t;

  localparam logic [4:0] AluAdd  = 5'd0;
  localparam logic [4:0] AluSub  = 5'd1;
  localparam logic [4:0] AluAnd  = 5'd2;
  localparam logic [4:0] AluOr   = 5'd3;
  localparam logic [4:0] AluXor  = 5'd4;
  localparam logic [4:0] AluSll  = 5'd5;
  localparam logic [4:0] AluSrl  = 5'd6;
  localparam logic [4:0] AluSra  = 5'd7;
  localparam logic [4:0] AluSlt  = 5'd8;
  localparam logic [4:0] AluSltu = 5'd9;

  // Operand: value plus producing ROB tag; tag 0 means the value is valid.
  typedef struct packed {
    logic [31:0] v;
    rob_id_t     q;
  } operand_t;

  typedef struct packed {
    logic              found;
    logic [RsIdxW-1:0] idx;
  } pick_t;

  // ALU bus wins if both buses carry the tag (not a legal situation).
  function automatic operand_t update_from_cdb(operand_t opnd,
                                               rob_id_t alu_id, logic [31:0] alu_val,
                                               rob_id_t mem_id, logic [31:0] mem_val);
    operand_t res;
    res = opnd;
    if (opnd.q != '0) begin
      if (opnd.q == alu_id) begin
        res.v = alu_val;
        res.q = '0;
      end else if (opnd.q == mem_id) begin
        res.v = mem_val;
        res.q = '0;
      end
    end
    return res;
  endfunction

  function automatic pick_t find_first_vacant(logic [RsDepth-1:0] busy);
    pick_t res;
    res = '0;
    for (int i = int'(RsDepth) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        res.found = 1'b1;
        res.idx   = RsIdxW'(i);
      end
    end
    return res;
  endfunction

  function automatic pick_t find_first_ready(logic [RsDepth-1:0] ready);
    pick_t res;
    res = '0;
    for (int i = int'(RsDepth) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        res.found = 1'b1;
        res.idx   = RsIdxW'(i);
      end
    end
    return res;
  endfunction

  function automatic logic [RsIdxW:0] count_vacancies(logic [RsDepth-1:0] busy);
    logic [RsIdxW:0] n;
    n = '0;
    for (int i = 0; i < int'(RsDepth); i++) begin
      if (!busy[i]) n = n + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rs_alu.sv
// 16-entry ALU reservation station: dispatch capture with CDB bypass, dual-CDB wakeup,
// lowest-index ready issue through registered outputs, flush clears all entries.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                dispatch_valid_in,
  input  logic [OP_WIDTH-1:0] dispatch_op_in,
  input  logic [31:0]         dispatch_Vj_in,
  input  logic [31:0]         dispatch_Vk_in,
  input  rob_id_t             dispatch_Qj_in,
  input  rob_id_t             dispatch_Qk_in,
  input  rob_id_t             dispatch_dest_in,
  input  logic [31:0]         cdb_alu_value_in,
  input  logic [31:0]         cdb_mem_value_in,
  input  rob_id_t             cdb_alu_rob_id_in,
  input  rob_id_t             cdb_mem_rob_id_in,
  output logic                full_out,
  output logic                alu_valid_out,
  output logic [OP_WIDTH-1:0] alu_op_out,
  output logic [31:0]         alu_a_out,
  output logic [31:0]         alu_b_out,
  output rob_id_t             alu_dest_out
);

  logic [RsDepth-1:0]  busy_q, busy_d;
  logic [RsDepth-1:0]  ready;
  logic [OP_WIDTH-1:0] op_q   [RsDepth];
  rob_id_t             dest_q [RsDepth];
  operand_t            opj_q  [RsDepth];
  operand_t            opk_q  [RsDepth];
  operand_t            opj_d  [RsDepth];
  operand_t            opk_d  [RsDepth];
  operand_t            wake_j [RsDepth];
  operand_t            wake_k [RsDepth];
  operand_t            disp_j, disp_k;
  pick_t               vac, sel;
  logic                disp_ok;
  logic                full_d;

  // Readiness uses pre-wakeup tags, so a woken entry issues one cycle later at the earliest.
  for (genvar i = 0; i < RsDepth; i++) begin : g_entry
    assign wake_j[i] = update_from_cdb(opj_q[i], cdb_alu_rob_id_in, cdb_alu_value_in,
                                       cdb_mem_rob_id_in, cdb_mem_value_in);
    assign wake_k[i] = update_from_cdb(opk_q[i], cdb_alu_rob_id_in, cdb_alu_value_in,
                                       cdb_mem_rob_id_in, cdb_mem_value_in);
    assign ready[i]  = busy_q[i] && (opj_q[i].q == '0) && (opk_q[i].q == '0);
  end

  assign disp_j = update_from_cdb({dispatch_Vj_in, dispatch_Qj_in},
                                  cdb_alu_rob_id_in, cdb_alu_value_in,
                                  cdb_mem_rob_id_in, cdb_mem_value_in);
  assign disp_k = update_from_cdb({dispatch_Vk_in, dispatch_Qk_in},
                                  cdb_alu_rob_id_in, cdb_alu_value_in,
                                  cdb_mem_rob_id_in, cdb_mem_value_in);

  always_comb begin
    vac     = find_first_vacant(busy_q);
    sel     = find_first_ready(ready);
    // Requests while full are dropped.
    disp_ok = dispatch_valid_in && !full_out && vac.found;

    busy_d = busy_q;
    if (sel.found) busy_d[sel.idx] = 1'b0;
    if (disp_ok)   busy_d[vac.idx] = 1'b1;
    full_d = (count_vacancies(busy_d) == '0);

    for (int i = 0; i < int'(RsDepth); i++) begin
      opj_d[i] = wake_j[i];
      opk_d[i] = wake_k[i];
    end
    if (disp_ok) begin
      opj_d[vac.idx] = disp_j;
      opk_d[vac.idx] = disp_k;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q        <= '0;
      full_out      <= 1'b0;
      alu_valid_out <= 1'b0;
      alu_op_out    <= '0;
      alu_a_out     <= '0;
      alu_b_out     <= '0;
      alu_dest_out  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_q        <= '0;
        full_out      <= 1'b0;
        alu_valid_out <= 1'b0;
      end else begin
        busy_q        <= busy_d;
        full_out      <= full_d;
        alu_valid_out <= sel.found;
        if (sel.found) begin
          alu_op_out   <= op_q[sel.idx];
          alu_a_out    <= opj_q[sel.idx].v;
          alu_b_out    <= opk_q[sel.idx].v;
          alu_dest_out <= dest_q[sel.idx];
        end
      end
    end
  end

  // Payload needs no reset: busy gates every use of it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush_in) begin
      for (int i = 0; i < int'(RsDepth); i++) begin
        opj_q[i] <= opj_d[i];
        opk_q[i] <= opk_d[i];
      end
      if (disp_ok) begin
        op_q[vac.idx]   <= dispatch_op_in;
        dest_q[vac.idx] <= dispatch_dest_in;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: behavioural slot model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        dispatch_valid;
  logic [4:0]  dispatch_op;
  logic [31:0] dispatch_vj, dispatch_vk;
  rob_id_t     dispatch_qj, dispatch_qk, dispatch_dest;
  logic [31:0] cdb_alu_value, cdb_mem_value;
  rob_id_t     cdb_alu_rob_id, cdb_mem_rob_id;
  logic        full_out, alu_valid_out;
  logic [4:0]  alu_op_out;
  logic [31:0] alu_a_out, alu_b_out;
  rob_id_t     alu_dest_out;

  always #5 clk = ~clk;

  rs_alu #(.OP_WIDTH(5)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .rdy_in            (rdy),
    .flush_in          (flush),
    .dispatch_valid_in (dispatch_valid),
    .dispatch_op_in    (dispatch_op),
    .dispatch_Vj_in    (dispatch_vj),
    .dispatch_Vk_in    (dispatch_vk),
    .dispatch_Qj_in    (dispatch_qj),
    .dispatch_Qk_in    (dispatch_qk),
    .dispatch_dest_in  (dispatch_dest),
    .cdb_alu_value_in  (cdb_alu_value),
    .cdb_mem_value_in  (cdb_mem_value),
    .cdb_alu_rob_id_in (cdb_alu_rob_id),
    .cdb_mem_rob_id_in (cdb_mem_rob_id),
    .full_out          (full_out),
    .alu_valid_out     (alu_valid_out),
    .alu_op_out        (alu_op_out),
    .alu_a_out         (alu_a_out),
    .alu_b_out         (alu_b_out),
    .alu_dest_out      (alu_dest_out)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference: a table of 16 waiting instructions.
  logic        m_busy [16];
  logic [4:0]  m_op   [16];
  logic [31:0] m_vj   [16];
  logic [31:0] m_vk   [16];
  rob_id_t     m_qj   [16];
  rob_id_t     m_qk   [16];
  rob_id_t     m_dest [16];
  logic        m_valid, m_full;
  logic [4:0]  m_aop;
  logic [31:0] m_a, m_b;
  rob_id_t     m_adest;

  function automatic logic [RobIdW+31:0] woken(logic [31:0] v, rob_id_t q);
    if (q != 0 && q == cdb_alu_rob_id) return {cdb_alu_value, rob_id_t'(0)};
    if (q != 0 && q == cdb_mem_rob_id) return {cdb_mem_value, rob_id_t'(0)};
    return {v, q};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sel, vac, nbusy;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_valid = 0; m_full = 0; m_aop = '0; m_a = '0; m_b = '0; m_adest = '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        m_valid = 0;
        m_full  = 0;
      end else begin
        sel = -1;
        vac = -1;
        for (int i = 15; i >= 0; i--) begin
          if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) sel = i;
          if (!m_busy[i]) vac = i;
        end
        m_valid = (sel >= 0);
        if (sel >= 0) begin
          m_aop = m_op[sel]; m_a = m_vj[sel]; m_b = m_vk[sel]; m_adest = m_dest[sel];
        end
        for (int i = 0; i < 16; i++) begin
          if (m_busy[i]) begin
            {m_vj[i], m_qj[i]} = woken(m_vj[i], m_qj[i]);
            {m_vk[i], m_qk[i]} = woken(m_vk[i], m_qk[i]);
          end
        end
        if (sel >= 0) m_busy[sel] = 1'b0;
        if (dispatch_valid) begin
          if (m_full) begin
            miscompares++;
            $display("FAIL protocol: dispatch_valid=1 while full_out=1, required 0");
          end else if (vac >= 0) begin
            m_busy[vac] = 1'b1;
            m_op[vac]   = dispatch_op;
            m_dest[vac] = dispatch_dest;
            {m_vj[vac], m_qj[vac]} = woken(dispatch_vj, dispatch_qj);
            {m_vk[vac], m_qk[vac]} = woken(dispatch_vk, dispatch_qk);
          end
        end
        nbusy = 0;
        for (int i = 0; i < 16; i++) if (m_busy[i]) nbusy++;
        m_full = (nbusy == 16);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    vectors++;
    chk("full_out", 32'(full_out), 32'(m_full));
    chk("alu_valid_out", 32'(alu_valid_out), 32'(m_valid));
    chk("alu_op_out", 32'(alu_op_out), 32'(m_aop));
    chk("alu_a_out", alu_a_out, m_a);
    chk("alu_b_out", alu_b_out, m_b);
    chk("alu_dest_out", 32'(alu_dest_out), 32'(m_adest));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0; dispatch_valid = 0;
    cdb_alu_rob_id = '0; cdb_mem_rob_id = '0;
  endtask

  task automatic set_disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input int qj, input int qk, input int dest);
    dispatch_valid = 1; dispatch_op = op; dispatch_vj = vj; dispatch_vk = vk;
    dispatch_qj = rob_id_t'(qj); dispatch_qk = rob_id_t'(qk); dispatch_dest = rob_id_t'(dest);
  endtask

  task automatic cdb_alu(input int id, input logic [31:0] val);
    cdb_alu_rob_id = rob_id_t'(id); cdb_alu_value = val;
  endtask

  task automatic cdb_mem(input int id, input logic [31:0] val);
    cdb_mem_rob_id = rob_id_t'(id); cdb_mem_value = val;
  endtask

  initial begin
    idle();
    rst = 1;
    dispatch_op = '0; dispatch_vj = '0; dispatch_vk = '0;
    dispatch_qj = '0; dispatch_qk = '0; dispatch_dest = '0;
    cdb_alu_value = '0; cdb_mem_value = '0;
    tick(); tick();
    idle();
    chk("reset valid", 32'(alu_valid_out), 32'h0);
    chk("reset full", 32'(full_out), 32'h0);
    chk("reset a", alu_a_out, 32'h0);
    chk("reset dest", 32'(alu_dest_out), 32'h0);

    // Ready dispatch: issue two edges after presentation.
    set_disp(AluAdd, 32'd5, 32'd7, 0, 0, 3);
    tick(); idle();
    chk("ready no early issue", 32'(alu_valid_out), 32'h0);
    tick();
    chk("ready valid", 32'(alu_valid_out), 32'h1);
    chk("ready a", alu_a_out, 32'd5);
    chk("ready b", alu_b_out, 32'd7);
    chk("ready dest", 32'(alu_dest_out), 32'd3);
    chk("ready op", 32'(alu_op_out), 32'(AluAdd));
    tick();
    chk("ready one-shot", 32'(alu_valid_out), 32'h0);

    // Wakeup from the memory CDB.
    set_disp(AluSub, 32'd0, 32'd1, 4, 0, 2);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("waiting no issue", 32'(alu_valid_out), 32'h0);
    end
    cdb_mem(4, 32'h1234);
    tick(); idle();
    chk("no same-cycle wake issue", 32'(alu_valid_out), 32'h0);
    tick();
    chk("wake valid", 32'(alu_valid_out), 32'h1);
    chk("wake a", alu_a_out, 32'h1234);
    chk("wake dest", 32'(alu_dest_out), 32'd2);
    tick();

    // Dispatch bypass from the ALU CDB.
    set_disp(AluAdd, 32'd3, 32'hdead, 0, 6, 8);
    cdb_alu(6, 32'd9);
    tick(); idle();
    tick();
    chk("bypass valid", 32'(alu_valid_out), 32'h1);
    chk("bypass b", alu_b_out, 32'd9);
    chk("bypass dest", 32'(alu_dest_out), 32'd8);
    tick();

    // Fill and drain in index order.
    for (int i = 0; i < 16; i++) begin
      set_disp(AluAnd, 32'(i), 32'(100 + i), 7, 0, i + 1);
      tick();
      if (i == 14) chk("fill 15 not full", 32'(full_out), 32'h0);
    end
    idle();
    chk("fill 16 full", 32'(full_out), 32'h1);
    cdb_alu(7, 32'h70);
    tick(); idle();
    chk("full after wake", 32'(full_out), 32'h1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain valid", 32'(alu_valid_out), 32'h1);
      chk("drain dest", 32'(alu_dest_out), 32'(i + 1));
      if (i == 0) chk("full drops on issue", 32'(full_out), 32'h0);
    end
    tick();
    chk("drained", 32'(alu_valid_out), 32'h0);

    // Dispatch and issue together at 15 busy.
    for (int i = 0; i < 15; i++) begin
      set_disp(AluOr, 32'd0, 32'(i), 8, 0, i + 1);
      tick();
    end
    idle();
    cdb_alu(8, 32'h80);
    tick(); idle();
    set_disp(AluXor, 32'h99, 32'h99, 9, 0, 20);
    tick(); idle();
    chk("simul issue dest", 32'(alu_dest_out), 32'd1);
    chk("simul full stays 0", 32'(full_out), 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("simul last of batch", 32'(alu_dest_out), 32'd15);
    tick();
    chk("new entry still waiting", 32'(alu_valid_out), 32'h0);
    cdb_mem(9, 32'h900);
    tick(); idle();
    tick();
    chk("new entry issue dest", 32'(alu_dest_out), 32'd20);
    chk("new entry issue a", alu_a_out, 32'h900);
    tick();

    // Flush with 10 busy and a dispatch in flight.
    for (int i = 0; i < 10; i++) begin
      set_disp(AluAdd, 32'd0, 32'd0, 10, 0, i + 1);
      tick();
    end
    set_disp(AluAdd, 32'd1, 32'd1, 0, 0, 11);
    flush = 1;
    tick(); idle();
    chk("flush valid", 32'(alu_valid_out), 32'h0);
    chk("flush full", 32'(full_out), 32'h0);
    cdb_alu(10, 32'hab);
    tick(); idle();
    tick();
    chk("no issue after flush", 32'(alu_valid_out), 32'h0);
    tick();
    chk("no issue after flush 2", 32'(alu_valid_out), 32'h0);

    // Stall: inputs ignored and state held.
    set_disp(AluSll, 32'd0, 32'd2, 11, 0, 5);
    tick(); idle();
    rdy = 0;
    cdb_alu(11, 32'h55);
    set_disp(AluAdd, 32'd1, 32'd1, 0, 0, 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall no issue", 32'(alu_valid_out), 32'h0);
    end
    idle();
    tick(); tick();
    chk("stall ignored cdb/dispatch", 32'(alu_valid_out), 32'h0);
    cdb_alu(11, 32'h66);
    tick(); idle();
    tick();
    chk("resume a", alu_a_out, 32'h66);
    chk("resume dest", 32'(alu_dest_out), 32'd5);
    set_disp(AluSrl, 32'd4, 32'd4, 0, 0, 7);
    tick(); idle();
    tick();
    rdy = 0;
    tick(); tick();
    chk("stall holds valid", 32'(alu_valid_out), 32'h1);
    chk("stall holds dest", 32'(alu_dest_out), 32'd7);
    rdy = 1;
    tick();
    chk("after stall valid", 32'(alu_valid_out), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      rdy   = rst ? 1'b1 : ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 63) == 0);
      dispatch_valid = !m_full && ($urandom_range(0, 1) == 1);
      dispatch_op    = 5'($urandom_range(0, 9));
      dispatch_vj    = $urandom;
      dispatch_vk    = $urandom;
      dispatch_qj    = ($urandom_range(0, 2) == 0) ? rob_id_t'(0) : rob_id_t'($urandom_range(1, 7));
      dispatch_qk    = ($urandom_range(0, 2) == 0) ? rob_id_t'(0) : rob_id_t'($urandom_range(1, 7));
      dispatch_dest  = rob_id_t'($urandom_range(1, 31));
      cdb_alu_rob_id = rob_id_t'($urandom_range(0, 7));
      cdb_mem_rob_id = rob_id_t'($urandom_range(0, 7));
      if (cdb_mem_rob_id == cdb_alu_rob_id) cdb_mem_rob_id = '0;
      cdb_alu_value  = $urandom;
      cdb_mem_value  = $urandom;
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
